pwm_capture: RTL and testbench



---
 rtl/pwm_capture.sv | 119 +++++++++++
 tb/tb_pwm_capture.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// ============================================================================
//  Module   : pwm_capture
//  Purpose  : Measures period and high time of an external PWM line and
//             flags a stuck-high / stuck-low line.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_capture #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pwm_in,
    output logic [W-1:0] period_out,
    output logic [W-1:0] duty_out,
    output logic         valid,
    output logic         stuck,
    output logic         level,
    output logic         locked
);

    localparam logic [W-1:0] c_MAX = '1;
    localparam logic [W-1:0] c_ONE = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    state_t       state_q;
    logic         s1_q;
    logic         pwm_s_q;
    logic         pwm_d_q;
    logic [W-1:0] period_cnt_q;
    logic [W-1:0] high_cnt_q;
    logic [W-1:0] period_q;
    logic [W-1:0] duty_q;
    logic         valid_q;
    logic         stuck_q;
    logic         level_q;
    logic         locked_q;
    logic         pwm_rise;

    assign pwm_rise = pwm_s_q & ~pwm_d_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q         <= 1'b0;
            pwm_s_q      <= 1'b0;
            pwm_d_q      <= 1'b0;
            state_q      <= ST_IDLE;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            period_q     <= '0;
            duty_q       <= '0;
            valid_q      <= 1'b0;
            stuck_q      <= 1'b0;
            level_q      <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            s1_q    <= pwm_in;
            pwm_s_q <= s1_q;
            pwm_d_q <= pwm_s_q;
            valid_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // First edge only arms the measurement; nothing to report yet.
                    if (pwm_rise) begin
                        state_q      <= ST_MEASURE;
                        period_cnt_q <= c_ONE;
                        high_cnt_q   <= c_ONE;
                        stuck_q      <= 1'b0;
                        locked_q     <= 1'b1;
                    end
                end

                ST_MEASURE: begin
                    if (pwm_rise) begin
                        period_q     <= period_cnt_q;
                        duty_q       <= high_cnt_q;
                        valid_q      <= 1'b1;
                        period_cnt_q <= c_ONE;
                        high_cnt_q   <= c_ONE;
                    end else if (period_cnt_q == c_MAX) begin
                        // No edge within MAX cycles: report the line as stuck.
                        state_q  <= ST_IDLE;
                        stuck_q  <= 1'b1;
                        level_q  <= pwm_s_q;
                        locked_q <= 1'b0;
                        valid_q  <= 1'b1;
                        period_q <= '0;
                        duty_q   <= pwm_s_q ? c_MAX : '0;
                    end else begin
                        period_cnt_q <= period_cnt_q + c_ONE;
                        if (pwm_s_q) begin
                            high_cnt_q <= high_cnt_q + c_ONE;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign period_out = period_q;
    assign duty_out   = duty_q;
    assign valid      = valid_q;
    assign stuck      = stuck_q;
    assign level      = level_q;
    assign locked     = locked_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_capture.sv
// ============================================================================
//  Module   : tb_pwm_capture
//  Purpose  : Scoreboard bench for pwm_capture against an edge-timestamp model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pwm_capture;

    localparam int W   = 8;
    localparam int MAX = 255;
    localparam int NE  = 16384;

    logic         clk;
    logic         rst_n;
    logic         pwm_in;
    logic [W-1:0] period_out;
    logic [W-1:0] duty_out;
    logic         valid;
    logic         stuck;
    logic         level;
    logic         locked;

    pwm_capture #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_in     (pwm_in),
        .period_out (period_out),
        .duty_out   (duty_out),
        .valid      (valid),
        .stuck      (stuck),
        .level      (level),
        .locked     (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int  due;
        int  period;
        int  duty;
        bit  tmo;
        bit  lvl;
    } rec_t;

    rec_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: works on the sequence of pwm_in values seen at each
    // rising clock edge; every report appears two edges after the sampled edge.
    int  ecnt = -1;
    bit  hist     [0:NE-1];
    bit  lock_at  [0:NE-1];
    bit  stuck_at [0:NE-1];
    bit  m_armed = 0;
    bit  m_prev  = 0;
    bit  m_stuck = 0;
    int  m_last  = 0;

    always @(posedge clk) begin
        int  j;
        bit  x;
        bit  r;
        rec_t rc;
        ecnt = ecnt + 1;
        j    = ecnt;
        x    = pwm_in;
        if (!rst_n) begin
            m_armed = 0;
            m_prev  = 0;
            m_stuck = 0;
            sb.delete();
            for (int k = 0; k < 3; k++) begin
                if (j + k < NE) begin
                    lock_at[j+k]  = 0;
                    stuck_at[j+k] = 0;
                end
            end
        end else if (j < NE) begin
            hist[j] = x;
            r       = x && !m_prev;
            m_prev  = x;
            if (m_armed && r) begin
                rc.due    = j + 2;
                rc.period = j - m_last;
                rc.duty   = 0;
                for (int k = m_last; k < j; k++) rc.duty += int'(hist[k]);
                rc.tmo    = 0;
                rc.lvl    = 0;
                sb.push_back(rc);
                m_last = j;
            end else if (m_armed && (j - m_last == MAX)) begin
                rc.due    = j + 2;
                rc.period = 0;
                rc.duty   = x ? MAX : 0;
                rc.tmo    = 1;
                rc.lvl    = x;
                sb.push_back(rc);
                m_armed = 0;
                m_stuck = 1;
            end else if (!m_armed && r) begin
                m_armed = 1;
                m_stuck = 0;
                m_last  = j;
            end
            if (j + 2 < NE) begin
                lock_at[j+2]  = m_armed;
                stuck_at[j+2] = m_stuck;
            end
        end
    end

    // Monitor: compares every cycle against the expected register image.
    initial begin
        int e;
        int cur_p = 0;
        int cur_d = 0;
        bit cur_l = 0;
        bit exp_v;
        forever begin
            @(posedge clk);
            #1;
            e     = ecnt;
            exp_v = 0;
            if (!rst_n) begin
                cur_p = 0;
                cur_d = 0;
                cur_l = 0;
            end else begin
                while (sb.size() > 0 && sb[0].due < e) begin
                    checks++;
                    errors++;
                    $display("FAIL stale_report edge=%0d due=%0d", e, sb[0].due);
                    void'(sb.pop_front());
                end
                if (sb.size() > 0 && sb[0].due == e) begin
                    exp_v = 1;
                    cur_p = sb[0].period;
                    cur_d = sb[0].duty;
                    if (sb[0].tmo) cur_l = sb[0].lvl;
                    void'(sb.pop_front());
                end
            end
            if (e < NE) begin
                checks++;
                if (valid !== exp_v || int'(period_out) != cur_p || int'(duty_out) != cur_d ||
                    level !== cur_l || locked !== lock_at[e] || stuck !== stuck_at[e]) begin
                    errors++;
                    $display("FAIL outputs edge=%0d got v=%0b p=%0d d=%0d lvl=%0b lk=%0b st=%0b exp v=%0b p=%0d d=%0d lvl=%0b lk=%0b st=%0b",
                             e, valid, period_out, duty_out, level, locked, stuck,
                             exp_v, cur_p, cur_d, cur_l, lock_at[e], stuck_at[e]);
                end
            end
        end
    end

    task automatic pwm_periods(input int per, input int hi, input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < per; i++) begin
                @(negedge clk);
                pwm_in = (i < hi);
            end
        end
    endtask

    task automatic hold(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pwm_in = v;
        end
    endtask

    initial begin
        int p;
        int h;
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;

        pwm_periods(20, 5, 6);
        pwm_periods(20, 15, 4);

        // Stuck low, then recovery.
        hold(0, 300);
        pwm_periods(20, 5, 3);

        // Stuck high, then recovery.
        hold(1, 300);
        hold(0, 5);
        pwm_periods(20, 5, 3);

        // Longest measurable period, then one cycle too long.
        pwm_periods(255, 100, 3);
        pwm_periods(256, 100, 2);
        pwm_periods(20, 5, 2);

        // Reset at cycle 10 of a 20-cycle period.
        pwm_periods(20, 5, 2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pwm_in = (i < 5);
        end
        @(negedge clk);
        pwm_in = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        hold(0, 8);
        pwm_periods(20, 5, 3);

        // Random periods, occasionally long enough to time out.
        for (int k = 0; k < 30; k++) begin
            p = ($urandom_range(0, 9) == 0) ? int'($urandom_range(200, 300))
                                            : int'($urandom_range(2, 60));
            h = $urandom_range(1, p - 1);
            pwm_periods(p, h, 1);
        end

        hold(0, 300);
        repeat (5) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
